// File: rtl/bsg_gateway_io_arbiter.sv
// Round-robin arbiter for two I/O requesters sharing one target, with in-order response routing.
// Define IO_ARB_TIMEOUT_EN to build the response-timeout counter; otherwise timeout_o is tied low.
module bsg_gateway_io_arbiter #(
  parameter int msg_width_p      = 128,
  parameter int tag_els_p        = 4,
  parameter int timeout_cycles_p = 1024
) (
  input  logic                               blackparrot_clk,
  input  logic                               blackparrot_reset,
  input  logic [msg_width_p-1:0]             req0_cmd_i,
  input  logic                               req0_cmd_v_i,
  output logic                               req0_cmd_yumi_o,
  input  logic [msg_width_p-1:0]             req1_cmd_i,
  input  logic                               req1_cmd_v_i,
  output logic                               req1_cmd_yumi_o,
  output logic [msg_width_p-1:0]             cmd_o,
  output logic                               cmd_v_o,
  input  logic                               cmd_ready_i,
  input  logic [msg_width_p-1:0]             resp_i,
  input  logic                               resp_v_i,
  output logic                               resp_yumi_o,
  output logic [msg_width_p-1:0]             req0_resp_o,
  output logic                               req0_resp_v_o,
  input  logic                               req0_resp_ready_i,
  output logic [msg_width_p-1:0]             req1_resp_o,
  output logic                               req1_resp_v_o,
  input  logic                               req1_resp_ready_i,
  output logic [$clog2(tag_els_p+1)-1:0]     outstanding_o,
  output logic                               spurious_o,
  output logic                               timeout_o
);

  localparam int ptr_w_lp = $clog2(tag_els_p);
  localparam int cnt_w_lp = $clog2(tag_els_p+1);
  localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(tag_els_p-1);
  localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(tag_els_p);

  // Tag FIFO: one bit per slot holding the requester id of an issued command.
  logic [tag_els_p-1:0] r_tags;
  logic [ptr_w_lp-1:0]  r_wptr;
  logic [ptr_w_lp-1:0]  r_rptr;
  logic [cnt_w_lp-1:0]  r_count;
  logic                 r_rr_ptr;
  logic                 r_spurious;

  logic w_run;
  logic w_full;
  logic w_empty;
  logic w_grant;
  logic w_cmd_v;
  logic w_push;
  logic w_head;
  logic w_resp_live;
  logic w_pop;

  // Outputs are gated by reset so nothing handshakes while reset is held.
  assign w_run   = blackparrot_reset;
  assign w_full  = (r_count == full_cnt_lp);
  assign w_empty = (r_count == '0);

  always_comb begin
    w_grant = 1'b0;
    if (req0_cmd_v_i && req1_cmd_v_i) begin
      w_grant = r_rr_ptr;
    end else if (req1_cmd_v_i) begin
      w_grant = 1'b1;
    end
  end

  assign w_cmd_v         = w_run & (req0_cmd_v_i | req1_cmd_v_i) & ~w_full;
  assign w_push          = w_cmd_v & cmd_ready_i;
  assign cmd_v_o         = w_cmd_v;
  assign cmd_o           = w_grant ? req1_cmd_i : req0_cmd_i;
  assign req0_cmd_yumi_o = w_push & ~w_grant;
  assign req1_cmd_yumi_o = w_push & w_grant;

  assign w_head        = r_tags[r_rptr];
  assign w_resp_live   = w_run & resp_v_i & ~w_empty;
  assign req0_resp_v_o = w_resp_live & ~w_head;
  assign req1_resp_v_o = w_resp_live & w_head;
  assign w_pop         = w_resp_live & (w_head ? req1_resp_ready_i : req0_resp_ready_i);
  assign resp_yumi_o   = w_pop;
  assign req0_resp_o   = resp_i;
  assign req1_resp_o   = resp_i;

  assign outstanding_o = r_count;
  assign spurious_o    = r_spurious;

  always_ff @(posedge blackparrot_clk or negedge blackparrot_reset) begin
    if (!blackparrot_reset) begin
      r_tags     <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_rr_ptr   <= 1'b0;
      r_spurious <= 1'b0;
    end else begin
      if (w_push) begin
        r_tags[r_wptr] <= w_grant;
        r_wptr         <= (r_wptr == last_ptr_lp) ? '0 : r_wptr + 1'b1;
        r_rr_ptr       <= ~w_grant;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == last_ptr_lp) ? '0 : r_rptr + 1'b1;
      end
      if (w_push != w_pop) begin
        r_count <= w_push ? r_count + 1'b1 : r_count - 1'b1;
      end
      if (resp_v_i && w_empty) begin
        r_spurious <= 1'b1;
      end
    end
  end

`ifdef IO_ARB_TIMEOUT_EN
  localparam int tmo_w_lp = $clog2(timeout_cycles_p+1);
  localparam logic [tmo_w_lp-1:0] tmo_lim_lp = tmo_w_lp'(timeout_cycles_p);

  logic [tmo_w_lp-1:0] r_tmo_cnt;
  logic                r_timeout;

  // Counts consecutive cycles the oldest command waits; saturates at the limit.
  always_ff @(posedge blackparrot_clk or negedge blackparrot_reset) begin
    if (!blackparrot_reset) begin
      r_tmo_cnt <= '0;
      r_timeout <= 1'b0;
    end else if (w_empty || w_pop) begin
      r_tmo_cnt <= '0;
    end else if (r_tmo_cnt != tmo_lim_lp) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
      if (r_tmo_cnt == tmo_lim_lp - 1'b1) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign timeout_o = r_timeout;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^timeout_cycles_p;
  assign timeout_o    = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_gateway_io_arbiter.sv
// Self-checking bench for bsg_gateway_io_arbiter: directed scenarios then random traffic,
// all checked against a queue-based reference model.
module tb_bsg_gateway_io_arbiter;
  localparam int W    = 16;
  localparam int TAGS = 4;
  localparam int TMO  = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] c0, c1, cmd, rdata, r0, r1;
  logic         v0, v1, y0, y1, cmd_v, rdy, rv, ryumi, rv0, rv1, rr0, rr1, spur, tmo;
  logic [2:0]   outst;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: queue of requester ids in issue order plus sticky flags.
  int tagq[$];
  bit m_rr   = 1'b0;
  bit m_spur = 1'b0;
  bit m_tmo  = 1'b0;
  int m_tcnt = 0;

  always #5 clk = ~clk;

  bsg_gateway_io_arbiter #(
    .msg_width_p(W), .tag_els_p(TAGS), .timeout_cycles_p(TMO)
  ) dut (
    .blackparrot_clk(clk),     .blackparrot_reset(rst_n),
    .req0_cmd_i(c0),           .req0_cmd_v_i(v0),         .req0_cmd_yumi_o(y0),
    .req1_cmd_i(c1),           .req1_cmd_v_i(v1),         .req1_cmd_yumi_o(y1),
    .cmd_o(cmd),               .cmd_v_o(cmd_v),           .cmd_ready_i(rdy),
    .resp_i(rdata),            .resp_v_i(rv),             .resp_yumi_o(ryumi),
    .req0_resp_o(r0),          .req0_resp_v_o(rv0),       .req0_resp_ready_i(rr0),
    .req1_resp_o(r1),          .req1_resp_v_o(rv1),       .req1_resp_ready_i(rr1),
    .outstanding_o(outst),     .spurious_o(spur),         .timeout_o(tmo)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model at the edge.
  task automatic cyc();
    bit run, full, empty, g, e_cv, hs, head, e_ry;
    @(negedge clk);
    #1;
    run   = rst_n;
    full  = (tagq.size() == TAGS);
    empty = (tagq.size() == 0);
    g     = (v0 && v1) ? m_rr : v1;
    e_cv  = run && (v0 || v1) && !full;
    hs    = e_cv && rdy;
    head  = 1'b0;
    if (!empty) head = (tagq[0] != 0);
    e_ry  = run && rv && !empty && (head ? rr1 : rr0);

    chk("cmd_v", cmd_v, e_cv);
    if (e_cv) chk("cmd_data", cmd, g ? c1 : c0);
    chk("cmd_yumi0", y0, hs && !g);
    chk("cmd_yumi1", y1, hs && g);
    chk("resp_v0", rv0, run && rv && !empty && !head);
    chk("resp_v1", rv1, run && rv && !empty && head);
    chk("resp_yumi", ryumi, e_ry);
    chk("resp0_data", r0, rdata);
    chk("resp1_data", r1, rdata);
    chk("outstanding", outst, run ? tagq.size() : 0);
    chk("spurious", spur, run ? m_spur : 1'b0);
    chk("timeout", tmo, run ? m_tmo : 1'b0);

    @(posedge clk);
    if (!run) begin
      tagq.delete();
      m_rr = 1'b0; m_spur = 1'b0; m_tmo = 1'b0; m_tcnt = 0;
    end else begin
      if (rv && empty) m_spur = 1'b1;
`ifdef IO_ARB_TIMEOUT_EN
      if (empty || e_ry) m_tcnt = 0;
      else if (m_tcnt < TMO) begin
        m_tcnt++;
        if (m_tcnt == TMO) m_tmo = 1'b1;
      end
`endif
      if (e_ry) void'(tagq.pop_front());
      if (hs) begin
        tagq.push_back(int'(g));
        m_rr = !g;
      end
    end
    #1;
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    v0 = 1; v1 = 1; rdy = 1; rv = 1; rr0 = 1; rr1 = 1;
    c0 = 16'hA000; c1 = 16'hB000; rdata = 16'h1234;
    repeat (2) cyc();                       // outputs held low during reset
    rst_n = 1'b1; rv = 0;

    repeat (4) begin c0++; c1++; cyc(); end // grants 0,1,0,1 fill the FIFO
    cyc();                                  // full: fifth request stalls
    chk("full_outstanding", outst, 3'd4);
    rv = 1; rdata = 16'h5A5A; cyc();        // pop while full: no issue this cycle
    rv = 0; cyc();                          // freed slot is used
    v0 = 0; v1 = 0; rv = 1;
    repeat (4) begin rdata = rdata + 16'h11; cyc(); end
    rv = 0;

    rst_pulse();
    v1 = 1; c1 = 16'h0101; cyc();
    v1 = 0; v0 = 1; c0 = 16'h0202; cyc();
    v0 = 0; v1 = 1; c1 = 16'h0303; cyc();
    v1 = 0;
    rv = 1; rr0 = 1; rr1 = 0; rdata = 16'hCAFE;
    repeat (2) cyc();                       // head belongs to req1, which is not ready
    rr1 = 1;
    repeat (3) begin rdata++; cyc(); end
    cyc();                                  // response with nothing outstanding
    rv = 0;
    repeat (2) cyc();
    chk("spurious_sticky", spur, 1'b1);

    rst_pulse();
    v0 = 1; cyc();
    v0 = 0;
    repeat (20) cyc();                      // no response: timeout window
`ifdef IO_ARB_TIMEOUT_EN
    chk("timeout_set", tmo, 1'b1);
`else
    chk("timeout_tied", tmo, 1'b0);
`endif

    v0 = 1; v1 = 1; repeat (2) cyc();       // three outstanding
    v0 = 0; v1 = 0;
    chk("pre_reset_outstanding", outst, 3'd3);
    rst_n = 0; v0 = 1; cyc();
    rst_n = 1; v0 = 0; rv = 1; cyc();       // late response after reset
    rv = 0; v1 = 1; c1 = 16'h7777; cyc();   // granted normally after reset
    v1 = 0; cyc();

    rst_pulse();
    for (int i = 0; i < 500; i++) begin
      v0    = ($urandom_range(0, 2) != 0);
      v1    = ($urandom_range(0, 2) != 0);
      rdy   = ($urandom_range(0, 3) != 0);
      rv    = ($urandom_range(0, 2) != 0) && (tagq.size() > 0 || $urandom_range(0, 29) == 0);
      rr0   = ($urandom_range(0, 2) != 0);
      rr1   = ($urandom_range(0, 2) != 0);
      c0    = W'($urandom);
      c1    = W'($urandom);
      rdata = W'($urandom);
      if ($urandom_range(0, 199) == 0) rst_n = 0;
      cyc();
      rst_n = 1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/bsg_gateway_io_arbiter.md
BSG_GATEWAY_IO_ARBITER -- requirements
Module: bsg_gateway_io_arbiter

Interface
REQ-001 Parameter msg_width_p, default 128, width of one I/O command or response message in bits.
REQ-002 Parameter tag_els_p, default 4, depth of the response-routing tag FIFO; legal range 2..16.
REQ-003 Parameter timeout_cycles_p, default 1024, response-timeout threshold in cycles.
REQ-004 blackparrot_clk  in  1  clock; reset is blackparrot_reset, asynchronous, active-low.
REQ-005 blackparrot_reset  in  1  asynchronous active-low reset.
REQ-006 req0_cmd_i / req1_cmd_i  in  msg_width_p  command from requester 0 (processor I/O) and requester 1 (loader).
REQ-007 req0_cmd_v_i / req1_cmd_v_i  in  1  command valid.
REQ-008 req0_cmd_yumi_o / req1_cmd_yumi_o  out  1  command consumed this cycle.
REQ-009 cmd_o  out  msg_width_p  command to the shared target; cmd_v_o out 1; cmd_ready_i in 1.
REQ-010 resp_i  in  msg_width_p  target response; resp_v_i in 1; resp_yumi_o out 1.
REQ-011 req0_resp_o / req1_resp_o  out  msg_width_p  routed response; reqN_resp_v_o out 1; reqN_resp_ready_i in 1.
REQ-012 outstanding_o  out  clog2(tag_els_p+1)  issued commands still awaiting a response.
REQ-013 spurious_o  out  1  sticky flag: response arrived with no outstanding command.
REQ-014 timeout_o  out  1  sticky flag: response overdue.

Function
REQ-015 Grant SHALL be round-robin between valid requesters; after reset, requester 0 has priority.
REQ-016 cmd_v_o SHALL be (req0_cmd_v_i | req1_cmd_v_i) & tag FIFO not full; cmd_o SHALL be the granted requester's command; latency zero (combinational pass-through).
REQ-017 reqN_cmd_yumi_o SHALL assert only for the granted requester, and only when cmd_v_o & cmd_ready_i.
REQ-018 On each command handshake the granted ID SHALL be pushed into the tag FIFO and the round-robin pointer SHALL move to favour the other requester.
REQ-019 Full is evaluated before any pop: a full FIFO SHALL block issue even when a response pops in the same cycle.
REQ-020 reqN_resp_v_o SHALL equal resp_v_i & FIFO not empty & head tag == N; resp_i SHALL be broadcast to both reqN_resp_o.
REQ-021 resp_yumi_o SHALL equal resp_v_i & not empty & ready of the head-tag requester; the FIFO pops on resp_yumi_o.
REQ-022 Responses SHALL return to requesters in issue order; no reordering.
REQ-023 A simultaneous push and pop (FIFO not full) SHALL leave outstanding_o unchanged; the pointers wrap modulo tag_els_p.
REQ-024 resp_v_i with an empty FIFO SHALL not be acknowledged and SHALL set spurious_o until reset.

Reset
REQ-025 While blackparrot_reset is low: FIFO empty, outstanding_o=0, round-robin pointer favours requester 0, spurious_o=0, timeout_o=0, timeout counter=0; all yumi and valid outputs SHALL be 0.
REQ-026 Reset asserted mid-transaction SHALL discard all outstanding tags; a late response after reset SHALL be treated per REQ-024.

Configuration
REQ-027 With IO_ARB_TIMEOUT_EN defined, a counter SHALL increment each cycle the FIFO is non-empty with no pop; it SHALL clear on pop or empty, and on reaching timeout_cycles_p it SHALL set timeout_o sticky until reset.
REQ-028 Without IO_ARB_TIMEOUT_EN, the counter SHALL be absent, the timeout_o port SHALL remain, and timeout_o SHALL be tied to 0.

Verification
REQ-029 Both requesters valid continuously, cmd_ready_i=1 -> grants alternate 0,1,0,1; the first grant after reset goes to 0.
REQ-030 Issue 4 commands with no response (tag_els_p=4) -> outstanding_o=4, cmd_v_o=0, and a 5th request is stalled; one response then frees exactly one slot.
REQ-031 Issue order 1,0,1, then 3 responses -> delivered to req1, req0, req1 in order; req1_resp_ready_i=0 stalls resp_yumi_o.
REQ-032 resp_v_i=1 with outstanding_o=0 -> resp_yumi_o=0 and spurious_o=1 the next cycle, persisting.
REQ-033 IO_ARB_TIMEOUT_EN, timeout_cycles_p=16, one command and no response -> timeout_o rises after 16 cycles; without the macro timeout_o stays 0.
REQ-034 Reset pulsed with outstanding_o=3 -> outstanding_o=0 and all outputs zero during reset; a subsequent request is granted normally.
